// File: rtl/npn_tt_probe.sv
// Truth-table probe for a 4-input, 1-output function block.
// Sweeps all 16 minterms, then optionally searches the 768 NPN transforms for the canonical form.
module npn_tt_probe #(
  parameter int SETTLE       = 1,
  parameter bit ENABLE_CANON = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  input  logic        y0,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [15:0] canon_tt,
  output logic [4:0]  canon_perm,
  output logic [3:0]  canon_neg,
  output logic        canon_onot
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SETTLE_L = CW'(SETTLE);

  typedef enum logic [1:0] {IDLE, PROBE, CANON, DONE} state_t;

  state_t        state;
  logic [3:0]    m;
  logic [3:0]    x_q;
  logic [CW-1:0] settle_cnt;
  logic [4:0]    k;
  logic [3:0]    n;

  logic [7:0]    tup;
  logic [3:0]    pm;
  logic [3:0]    mv;
  logic [15:0]   g;
  logic [15:0]   best_tt;
  logic [4:0]    best_perm;
  logic [3:0]    best_neg;
  logic          best_onot;

  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];

  // Packed {p3,p2,p1,p0}, tuples in lexicographic order.
  function automatic logic [7:0] perm_tuple(input logic [4:0] idx);
    logic [7:0] t;
    case (idx)
      5'd0:    t = {2'd3, 2'd2, 2'd1, 2'd0};
      5'd1:    t = {2'd2, 2'd3, 2'd1, 2'd0};
      5'd2:    t = {2'd3, 2'd1, 2'd2, 2'd0};
      5'd3:    t = {2'd1, 2'd3, 2'd2, 2'd0};
      5'd4:    t = {2'd2, 2'd1, 2'd3, 2'd0};
      5'd5:    t = {2'd1, 2'd2, 2'd3, 2'd0};
      5'd6:    t = {2'd3, 2'd2, 2'd0, 2'd1};
      5'd7:    t = {2'd2, 2'd3, 2'd0, 2'd1};
      5'd8:    t = {2'd3, 2'd0, 2'd2, 2'd1};
      5'd9:    t = {2'd0, 2'd3, 2'd2, 2'd1};
      5'd10:   t = {2'd2, 2'd0, 2'd3, 2'd1};
      5'd11:   t = {2'd0, 2'd2, 2'd3, 2'd1};
      5'd12:   t = {2'd3, 2'd1, 2'd0, 2'd2};
      5'd13:   t = {2'd1, 2'd3, 2'd0, 2'd2};
      5'd14:   t = {2'd3, 2'd0, 2'd1, 2'd2};
      5'd15:   t = {2'd0, 2'd3, 2'd1, 2'd2};
      5'd16:   t = {2'd1, 2'd0, 2'd3, 2'd2};
      5'd17:   t = {2'd0, 2'd1, 2'd3, 2'd2};
      5'd18:   t = {2'd2, 2'd1, 2'd0, 2'd3};
      5'd19:   t = {2'd1, 2'd2, 2'd0, 2'd3};
      5'd20:   t = {2'd2, 2'd0, 2'd1, 2'd3};
      5'd21:   t = {2'd0, 2'd2, 2'd1, 2'd3};
      5'd22:   t = {2'd1, 2'd0, 2'd2, 2'd3};
      5'd23:   t = {2'd0, 2'd1, 2'd2, 2'd3};
      default: t = {2'd3, 2'd2, 2'd1, 2'd0};
    endcase
    return t;
  endfunction

  always_comb begin
    tup = perm_tuple(k);
    pm  = '0;
    mv  = '0;
    g   = '0;
    for (int i = 0; i < 16; i++) begin
      mv    = 4'(i);
      pm[0] = mv[tup[1:0]];
      pm[1] = mv[tup[3:2]];
      pm[2] = mv[tup[5:4]];
      pm[3] = mv[tup[7:6]];
      g[i]  = tt[pm ^ n];
    end
  end

  // g is tried before ~g and only a strictly smaller value wins, so ties keep the earliest candidate.
  always_comb begin
    best_tt   = canon_tt;
    best_perm = canon_perm;
    best_neg  = canon_neg;
    best_onot = canon_onot;
    if ((k == 5'd0 && n == 4'd0) || (g < best_tt)) begin
      best_tt   = g;
      best_perm = k;
      best_neg  = n;
      best_onot = 1'b0;
    end
    if (~g < best_tt) begin
      best_tt   = ~g;
      best_perm = k;
      best_neg  = n;
      best_onot = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      m          <= '0;
      x_q        <= '0;
      settle_cnt <= '0;
      k          <= '0;
      n          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt         <= '0;
      canon_tt   <= '0;
      canon_perm <= '0;
      canon_neg  <= '0;
      canon_onot <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          x_q <= '0;
          if (start) begin
            state      <= PROBE;
            busy       <= 1'b1;
            m          <= '0;
            settle_cnt <= '0;
            tt         <= '0;
            canon_tt   <= '0;
            canon_perm <= '0;
            canon_neg  <= '0;
            canon_onot <= 1'b0;
          end
        end
        PROBE: begin
          if (settle_cnt == SETTLE_L) begin
            tt[m]      <= y0;
            settle_cnt <= '0;
            if (m == 4'd15) begin
              x_q   <= '0;
              k     <= '0;
              n     <= '0;
              state <= ENABLE_CANON ? CANON : DONE;
            end else begin
              m   <= m + 4'd1;
              x_q <= m + 4'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        CANON: begin
          canon_tt   <= best_tt;
          canon_perm <= best_perm;
          canon_neg  <= best_neg;
          canon_onot <= best_onot;
          n          <= n + 4'd1;
          if (n == 4'd15) begin
            if (k == 5'd23) state <= DONE;
            else            k     <= k + 5'd1;
          end
        end
        DONE: begin
          if (!ENABLE_CANON) canon_tt <= tt;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
